// File: rtl/irq_request_latch_if.sv
// Request/acknowledge bundle between the irq_request_latch and its consumer.
// The master side drives event lines, mask and acks; the slave side is the latch.
interface irq_request_latch_if #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 3
);
  logic [WIDTH-1:0] irq_in;
  logic [WIDTH-1:0] mask;
  logic             ack;
  logic [ID_W-1:0]  ack_id;
  logic             clr_all;
  logic [WIDTH-1:0] req_vec;
  logic             valid;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] ovf;
  logic             ack_err;

  modport master (
    output irq_in, mask, ack, ack_id, clr_all,
    input  req_vec, valid, pend, ovf, ack_err
  );

  modport slave (
    input  irq_in, mask, ack, ack_id, clr_all,
    output req_vec, valid, pend, ovf, ack_err
  );
endinterface

// File: rtl/irq_request_latch.sv
// Rising-edge request capture with pending/overflow latches feeding an 8:3 encoder.
// Define IRQ_SYNC_EN to insert a two-flop synchronizer on irq_in (+2 cycles latency).
module irq_request_latch #(
  parameter int WIDTH = 8,
  parameter int ID_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  irq_request_latch_if.slave  bus
);

  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic             ack_err_q, ack_err_d;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Reset to all-ones so lines already high at reset release are not seen as events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= bus.irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = bus.irq_in;
`endif

  assign rise = samp & ~prev_q;

  always_comb begin
    clear = '0;
    for (int i = 0; i < WIDTH; i++) begin
      clear[i] = bus.ack & (bus.ack_id == ID_W'(i));
    end
  end

  always_comb begin
    prev_d    = samp;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    ack_err_d = 1'b0;
    if (bus.clr_all) begin
      pend_d = '0;
      ovf_d  = '0;
    end else begin
      // A rise in the same cycle as its own ack wins, so the new event survives.
      pend_d    = (pend_q & ~clear) | rise;
      ovf_d     = ovf_q | (rise & pend_q & ~clear);
      ack_err_d = bus.ack & ~(|(pend_q & clear));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '1;
      pend_q    <= '0;
      ovf_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.req_vec = pend_q & bus.mask;
  assign bus.valid   = |(pend_q & bus.mask);
  assign bus.pend    = pend_q;
  assign bus.ovf     = ovf_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed plus randomized bench for irq_request_latch against an event-level model.
module tb_irq_request_latch;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  irq_request_latch_if #(.WIDTH(8), .ID_W(3)) bus ();

  irq_request_latch #(.WIDTH(8), .ID_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state: what each line has "seen" and what is owed to the consumer.
  bit [7:0] m_pend, m_ovf, m_last;
  bit       m_err;
  bit [7:0] m_pipe [0:1];

  task automatic model_reset();
    m_pend = 8'h00;
    m_ovf  = 8'h00;
    m_err  = 1'b0;
    m_last = 8'hFF;
    m_pipe[0] = 8'hFF;
    m_pipe[1] = 8'hFF;
  endtask

  task automatic model_step();
    bit [7:0] seen;
    bit       hit;
    if (LAT == 0) seen = bus.irq_in;
    else begin
      seen      = m_pipe[0];
      m_pipe[0] = m_pipe[1];
      m_pipe[1] = bus.irq_in;
    end
    if (bus.clr_all) begin
      m_pend = 8'h00;
      m_ovf  = 8'h00;
      m_err  = 1'b0;
    end else begin
      m_err = bus.ack && (m_pend[bus.ack_id] == 1'b0);
      for (int i = 0; i < 8; i++) begin
        hit = bus.ack && (int'(bus.ack_id) == i);
        if (seen[i] && !m_last[i]) begin
          if (m_pend[i] && !hit) m_ovf[i] = 1'b1;
          m_pend[i] = 1'b1;
        end else if (hit) begin
          m_pend[i] = 1'b0;
        end
      end
    end
    m_last = seen;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk8({tag, ".pend"},    bus.pend,    m_pend);
    chk8({tag, ".req_vec"}, bus.req_vec, m_pend & bus.mask);
    chk1({tag, ".valid"},   bus.valid,   |(m_pend & bus.mask));
    chk8({tag, ".ovf"},     bus.ovf,     m_ovf);
    chk1({tag, ".ack_err"}, bus.ack_err, m_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    chk8({tag, ".pend_now"}, bus.pend, 8'h00);
    chk8({tag, ".ovf_now"},  bus.ovf,  8'h00);
    chk1({tag, ".valid_now"}, bus.valid, 1'b0);
    chk1({tag, ".err_now"},  bus.ack_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lines, input string tag);
    bus.irq_in = lines;
    tick(tag);
    bus.irq_in = 8'h00;
    repeat (LAT) tick(tag);
  endtask

  initial begin
    bus.irq_in  = 8'h00;
    bus.mask    = 8'hFF;
    bus.ack     = 1'b0;
    bus.ack_id  = 3'd0;
    bus.clr_all = 1'b0;
    #2;
    do_reset("reset");
    check_all("reset");
    repeat (LAT + 2) tick("idle");

    // Single event, then its acknowledge.
    pulse(8'h20, "ev20");
    chk8("ev20.pend_c", bus.pend, 8'h20);
    chk1("ev20.valid_c", bus.valid, 1'b1);
    bus.ack = 1'b1; bus.ack_id = 3'd5;
    tick("ack5");
    bus.ack = 1'b0;
    chk8("ack5.pend_c", bus.pend, 8'h00);
    chk1("ack5.err_c", bus.ack_err, 1'b0);

    // Masked line latches and shows up once unmasked.
    bus.mask = 8'h01;
    pulse(8'h81, "ev81");
    chk8("ev81.req_c", bus.req_vec, 8'h01);
    bus.mask = 8'hFF;
    #1;
    check_all("unmask");
    chk8("unmask.req_c", bus.req_vec, 8'h81);
    bus.ack = 1'b1; bus.ack_id = 3'd0;
    tick("ack0");
    bus.ack_id = 3'd7;
    tick("ack7");
    bus.ack = 1'b0;
    chk8("b2b.pend_c", bus.pend, 8'h00);

    // Overflow on a pending line, then clr_all.
    pulse(8'h08, "ev08a");
    tick("gap");
    pulse(8'h08, "ev08b");
    chk8("ovf.ovf_c", bus.ovf, 8'h08);
    chk8("ovf.pend_c", bus.pend, 8'h08);
    bus.clr_all = 1'b1;
    tick("clr");
    bus.clr_all = 1'b0;
    chk8("clr.ovf_c", bus.ovf, 8'h00);
    chk8("clr.pend_c", bus.pend, 8'h00);

    // Rise and ack on the same line in the same cycle: set wins, no overflow.
    pulse(8'h04, "ev04");
    tick("gap2");
    bus.irq_in = 8'h04;
    repeat (LAT) tick("pre");
    bus.ack = 1'b1; bus.ack_id = 3'd2;
    tick("race");
    bus.ack = 1'b0; bus.irq_in = 8'h00;
    chk8("race.pend_c", bus.pend, 8'h04);
    chk8("race.ovf_c", bus.ovf, 8'h00);
    bus.ack = 1'b1;
    tick("ack2");
    bus.ack = 1'b0;
    repeat (LAT) tick("drain");

    // Ack of a non-pending line.
    pulse(8'h01, "ev01");
    bus.ack = 1'b1; bus.ack_id = 3'd6;
    tick("bad_ack");
    bus.ack = 1'b0;
    chk1("bad_ack.err_c", bus.ack_err, 1'b1);
    chk8("bad_ack.pend_c", bus.pend, 8'h01);
    tick("bad_ack2");
    chk1("bad_ack2.err_c", bus.ack_err, 1'b0);

    // Held-high lines across reset release, then a fresh rise on line 0.
    bus.irq_in = 8'hFF;
    do_reset("held");
    repeat (LAT + 2) tick("held");
    chk8("held.pend_c", bus.pend, 8'h00);
    bus.irq_in = 8'hFE;
    repeat (LAT + 1) tick("drop0");
    bus.irq_in = 8'hFF;
    for (int e = 1; e <= LAT + 1; e++) begin
      tick("raise0");
      chk8("raise0.pend_c", bus.pend, (e == LAT + 1) ? 8'h01 : 8'h00);
    end

    // Mid-run reset with state present.
    bus.irq_in = 8'h7F;
    repeat (LAT + 1) tick("pre_rst");
    do_reset("midrst");
    bus.irq_in = 8'h00;
    repeat (LAT + 2) tick("post_rst");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bus.irq_in  = bus.irq_in ^ 8'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) bus.mask = 8'($urandom);
      bus.ack     = ($urandom_range(0, 2) == 0);
      bus.ack_id  = 3'($urandom);
      bus.clr_all = ($urandom_range(0, 31) == 0);
      tick("rand");
    end
    bus.ack = 1'b0; bus.clr_all = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
